// File: rtl/pokey_audio.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pokey_audio : POKEY-compatible four-channel tone/noise generator       |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
module pokey_audio #(
  parameter int BASE64_DIV = 28,
  parameter int BASE15_DIV = 114
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       ce,
  input  logic       cs,
  input  logic       rw,
  input  logic [3:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [5:0] aud_mix
);

  localparam logic [6:0] DIV64_MAX = 7'(BASE64_DIV - 1);
  localparam logic [6:0] DIV15_MAX = 7'(BASE15_DIV - 1);

  logic [7:0]  audf [4];
  logic [7:0]  audc [4];
  logic [7:0]  audctl;
  logic [1:0]  skctl;
  logic [3:0]  out_ff;
  logic [1:0]  hp;
  logic [3:0]  poly4;
  logic [4:0]  poly5;
  logic [8:0]  poly9;
  logic [16:0] poly17;
  logic [6:0]  div;
  logic [6:0]  div_max;
  logic        init;
  logic        wr;
  logic        stimer;
  logic        base_tick;
  logic [3:0]  uf;
  logic [3:0]  eff;
  logic [5:0]  sum;

  assign init      = (skctl == 2'b00);
  assign wr        = ce & cs & ~rw;
  assign stimer    = wr & (addr == 4'h9);
  assign div_max   = audctl[0] ? DIV15_MAX : DIV64_MAX;
  assign base_tick = ce & ~init & (div >= div_max);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        audf[i] <= '0;
        audc[i] <= '0;
      end
      audctl <= '0;
      skctl  <= '0;
    end else if (wr) begin
      case (addr)
        4'h0: audf[0] <= din;
        4'h1: audc[0] <= din;
        4'h2: audf[1] <= din;
        4'h3: audc[1] <= din;
        4'h4: audf[2] <= din;
        4'h5: audc[2] <= din;
        4'h6: audf[3] <= din;
        4'h7: audc[3] <= din;
        4'h8: audctl  <= din;
        4'hF: skctl   <= din[1:0];
        default: ;
      endcase
    end
  end

  // Polys are reseeded to all ones while SKCTL holds the chip in init.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      poly4  <= '1;
      poly5  <= '1;
      poly9  <= '1;
      poly17 <= '1;
      div    <= '0;
    end else if (ce) begin
      if (init) begin
        poly4  <= '1;
        poly5  <= '1;
        poly9  <= '1;
        poly17 <= '1;
        div    <= '0;
      end else begin
        poly4  <= {poly4[2:0],   poly4[3]   ^ poly4[2]};
        poly5  <= {poly5[3:0],   poly5[4]   ^ poly5[2]};
        poly9  <= {poly9[7:0],   poly9[8]   ^ poly9[4]};
        poly17 <= {poly17[15:0], poly17[16] ^ poly17[13]};
        div    <= (div >= div_max) ? 7'd0 : div + 7'd1;
      end
    end
  end

  // Each pair (ch1/ch2, ch3/ch4) owns a 16-bit counter that runs either as
  // two independent 8-bit dividers or as one joined 16-bit divider.
  for (genvar p = 0; p < 2; p++) begin : g_pair
    localparam int LO = 2 * p;
    localparam int HI = 2 * p + 1;
    logic        fast;
    logic        joined;
    logic        tick_lo;
    logic [7:0]  rel_lo;
    logic [7:0]  rel_hi;
    logic [15:0] rel16;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic        uf_lo;
    logic        uf_hi;

    assign fast    = (p == 0) ? audctl[6] : audctl[5];
    assign joined  = (p == 0) ? audctl[4] : audctl[3];
    assign tick_lo = fast ? (ce & ~init) : base_tick;
    assign rel_lo  = audf[LO] + (fast ? 8'd3 : 8'd0);
    assign rel_hi  = audf[HI];
    assign rel16   = {audf[HI], audf[LO]} + (fast ? 16'd6 : 16'd0);

    always_comb begin
      cnt_nxt = cnt;
      uf_lo   = 1'b0;
      uf_hi   = 1'b0;
      if (joined) begin
        if (stimer) begin
          cnt_nxt = rel16;
        end else if (tick_lo) begin
          if (cnt == 16'd0) begin
            cnt_nxt = rel16;
            uf_hi   = 1'b1;
          end else begin
            cnt_nxt = cnt - 16'd1;
          end
        end
      end else if (stimer) begin
        cnt_nxt = {rel_hi, rel_lo};
      end else begin
        if (tick_lo) begin
          if (cnt[7:0] == 8'd0) begin
            cnt_nxt[7:0] = rel_lo;
            uf_lo        = 1'b1;
          end else begin
            cnt_nxt[7:0] = cnt[7:0] - 8'd1;
          end
        end
        if (base_tick) begin
          if (cnt[15:8] == 8'd0) begin
            cnt_nxt[15:8] = rel_hi;
            uf_hi         = 1'b1;
          end else begin
            cnt_nxt[15:8] = cnt[15:8] - 8'd1;
          end
        end
      end
    end

    always_ff @(posedge sysclk or posedge reset) begin
      if (reset) cnt <= '0;
      else       cnt <= cnt_nxt;
    end

    assign uf[LO] = uf_lo;
    assign uf[HI] = uf_hi;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      out_ff <= '0;
      hp     <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (uf[i] && (audc[i][7] || poly5[4])) begin
          if (audc[i][5])      out_ff[i] <= ~out_ff[i];
          else if (audc[i][6]) out_ff[i] <= poly4[3];
          else                 out_ff[i] <= audctl[7] ? poly9[8] : poly17[16];
        end
      end
      // The low half of a joined pair only divides; its output stays silent.
      if (audctl[4]) out_ff[0] <= 1'b0;
      if (audctl[3]) out_ff[2] <= 1'b0;
      if (!audctl[2])  hp[0] <= 1'b0;
      else if (uf[2])  hp[0] <= out_ff[0];
      if (!audctl[1])  hp[1] <= 1'b0;
      else if (uf[3])  hp[1] <= out_ff[1];
    end
  end

  always_comb begin
    eff = out_ff ^ {2'b00, hp};
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      if (audc[i][4] || eff[i]) sum = sum + {2'b00, audc[i][3:0]};
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) aud_mix <= '0;
    else       aud_mix <= sum;
  end

  assign dout = (addr == 4'hA) ? (audctl[7] ? poly9[7:0] : poly17[7:0]) : 8'hFF;

endmodule
`default_nettype wire
